// File: rtl/cpu16_defs.sv
// Shared definitions for the 16-bit multi-cycle CPU.
// Opcodes, 4-bit FSM state encodings and datapath control codes.
package cpu16_defs;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_LW    = 3'b001;
    localparam logic [2:0] OP_SW    = 3'b010;
    localparam logic [2:0] OP_BEQ   = 3'b011;
    localparam logic [2:0] OP_J     = 3'b100;
    localparam logic [2:0] OP_ADDI  = 3'b101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_TWO  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the 16-bit multi-cycle CPU.
// Drives every datapath strobe from state + memory wait counter.
module multicycle_control_fsm
    import cpu16_defs::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] opcode,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    localparam int WW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
    localparam logic [WW-1:0] LAST = WW'(MEM_LATENCY);

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt;
    logic          is_store;
    logic          last;

    assign last = (wait_cnt == LAST);

    // Load/store choice is captured in DECODE so MEMADR never looks at opcode.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            is_store <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (!last)
                wait_cnt <= wait_cnt + WW'(1);
            if (state == S_DECODE)
                is_store <= (opcode == OP_SW);
        end
    end

    always_comb begin
        state_nxt   = state;
        ALUOp       = ALU_ADD;
        ALUSrcB     = SRCB_B;
        PCSource    = PCSRC_ALU;
        ALUSrcA     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        RegWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        illegal_op  = 1'b0;
        state_dbg   = state;

        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_TWO;
                if (last) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_BOFF;
                case (opcode)
                    OP_RTYPE:     state_nxt = S_EXEC_R;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_EXEC_I;
                    default:      state_nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = is_store ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (last)
                    state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWRITE: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                state_nxt = S_FETCH;
            end
            S_EXEC_R: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALU_FUNCT;
                state_nxt = S_R_WB;
            end
            S_R_WB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_EXEC_I: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = S_I_WB;
            end
            S_I_WB: begin
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                state_nxt   = S_FETCH;
            end
            S_JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = PCSRC_JUMP;
                state_nxt = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
                state_nxt  = S_FETCH;
            end
            default: begin
                state_dbg = '0;
                state_nxt = S_FETCH;
            end
        endcase

        if (reset) begin
            {ALUOp, ALUSrcB, PCSource, ALUSrcA, RegDst, MemtoReg,
             MemRead, MemWrite, IorD, RegWrite, IRWrite, PCWrite,
             PCWriteCond, illegal_op, state_dbg} = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm (MEM_LATENCY=1).
module tb_multicycle_control_fsm;
    import cpu16_defs::*;

    localparam int ML = 1;

    typedef struct packed {
        logic [1:0] aluop;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       srca;
        logic       regdst;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       regwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       pcwcond;
        logic       illegal;
        logic [3:0] st;
    } ctl_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] opcode = 3'b000;
    logic [1:0] ALUOp, ALUSrcB, PCSource;
    logic       ALUSrcA, RegDst, MemtoReg, MemRead, MemWrite, IorD;
    logic       RegWrite, IRWrite, PCWrite, PCWriteCond, illegal_op;
    logic [3:0] state_dbg;

    int   tests = 0;
    int   fails = 0;
    int   memwrite_cnt;
    int   regwrite_cnt;
    int   illegal_cnt;
    ctl_t q[$];

    multicycle_control_fsm #(.MEM_LATENCY(ML)) dut (
        .clock(clock), .reset(reset), .opcode(opcode),
        .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUSrcA(ALUSrcA), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .illegal_op(illegal_op),
        .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    function automatic ctl_t c_st(logic [3:0] st);
        ctl_t c = '0;
        c.st = st;
        return c;
    endfunction

    task automatic push_fetch();
        ctl_t c;
        for (int i = 0; i <= ML; i++) begin
            c = c_st(S_FETCH);
            c.memread = 1'b1;
            c.srcb    = 2'b01;
            c.irwrite = (i == ML);
            c.pcwrite = (i == ML);
            q.push_back(c);
        end
        c = c_st(S_DECODE);
        c.srcb = 2'b11;
        q.push_back(c);
    endtask

    task automatic push_instr(logic [2:0] op);
        ctl_t c;
        push_fetch();
        case (op)
            3'b000: begin
                c = c_st(S_EXEC_R);
                c.srca = 1; c.aluop = 2'b10;
                q.push_back(c);
                c = c_st(S_R_WB);
                c.regwrite = 1; c.regdst = 1;
                q.push_back(c);
            end
            3'b001, 3'b010: begin
                c = c_st(S_MEMADR);
                c.srca = 1; c.srcb = 2'b10;
                q.push_back(c);
                if (op == 3'b001) begin
                    for (int i = 0; i <= ML; i++) begin
                        c = c_st(S_MEMREAD);
                        c.memread = 1; c.iord = 1;
                        q.push_back(c);
                    end
                    c = c_st(S_MEM_WB);
                    c.regwrite = 1; c.memtoreg = 1;
                    q.push_back(c);
                end else begin
                    c = c_st(S_MEMWRITE);
                    c.memwrite = 1; c.iord = 1;
                    q.push_back(c);
                end
            end
            3'b011: begin
                c = c_st(S_BRANCH);
                c.srca = 1; c.aluop = 2'b01;
                c.pcwcond = 1; c.pcsrc = 2'b01;
                q.push_back(c);
            end
            3'b100: begin
                c = c_st(S_JUMP);
                c.pcwrite = 1; c.pcsrc = 2'b10;
                q.push_back(c);
            end
            3'b101: begin
                c = c_st(S_EXEC_I);
                c.srca = 1; c.srcb = 2'b10;
                q.push_back(c);
                c = c_st(S_I_WB);
                c.regwrite = 1;
                q.push_back(c);
            end
            default: begin
                c = c_st(S_ILLEGAL);
                c.illegal = 1;
                q.push_back(c);
            end
        endcase
    endtask

    // One cycle: compare at negedge, then advance to just after posedge.
    task automatic step(string name);
        ctl_t obs, exp;
        @(negedge clock);
        obs = {ALUOp, ALUSrcB, PCSource, ALUSrcA, RegDst, MemtoReg,
               MemRead, MemWrite, IorD, RegWrite, IRWrite, PCWrite,
               PCWriteCond, illegal_op, state_dbg};
        memwrite_cnt += int'(MemWrite);
        regwrite_cnt += int'(RegWrite);
        illegal_cnt  += int'(illegal_op);
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty, got %h", name, obs);
        end else begin
            exp = q.pop_front();
            if (obs !== exp) begin
                fails++;
                $display("FAIL %s: got %h want %h", name, obs, exp);
            end
        end
        tests++;
        if ((int'(RegWrite) + int'(MemWrite) + int'(PCWriteCond)) > 1 ||
            (IRWrite === 1'b1 && state_dbg !== S_FETCH)) begin
            fails++;
            $display("FAIL %s exclusivity: got %h want one-hot strobes", name, obs);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_instr(logic [2:0] op, string name);
        opcode = op;
        memwrite_cnt = 0;
        regwrite_cnt = 0;
        illegal_cnt  = 0;
        push_instr(op);
        while (q.size() > 0) step(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            q.push_back('0);
            step("reset");
        end
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        run_instr(3'b000, "rtype");
    endtask

    task automatic test_lw();
        run_instr(3'b001, "lw");
        tests++;
        if (regwrite_cnt !== 1) begin
            fails++;
            $display("FAIL lw regwrite count: got %0d want 1", regwrite_cnt);
        end
    endtask

    task automatic test_sw();
        run_instr(3'b010, "sw");
        tests++;
        if (memwrite_cnt !== 1 || regwrite_cnt !== 0) begin
            fails++;
            $display("FAIL sw strobes: got mw=%0d rw=%0d want mw=1 rw=0",
                     memwrite_cnt, regwrite_cnt);
        end
    endtask

    task automatic test_back_to_back();
        run_instr(3'b011, "beq");
        run_instr(3'b100, "j");
        run_instr(3'b101, "addi");
    endtask

    task automatic test_illegal();
        run_instr(3'b111, "illegal111");
        tests++;
        if (illegal_cnt !== 1) begin
            fails++;
            $display("FAIL illegal pulse: got %0d want 1", illegal_cnt);
        end
        run_instr(3'b110, "illegal110");
    endtask

    task automatic test_reset_mid_memread();
        opcode = 3'b001;
        push_instr(3'b001);
        for (int i = 0; i < 4 + ML; i++) step("abort_lw");
        q.delete();
        reset = 1'b1;
        q.push_back('0);
        step("abort_reset");
        reset = 1'b0;
        run_instr(3'b100, "after_abort");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_sw();
        test_back_to_back();
        test_illegal();
        test_reset_mid_memread();
        test_rtype();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
